// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load/branch stall detection and
// an IDLE/RUN/DONE sequencer that holds the pipeline for iterative mul/div.
module hazard_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] rs_E,
  input  logic [4:0] rt_E,
  input  logic [4:0] writereg_E,
  input  logic [4:0] writereg_M,
  input  logic [4:0] writereg_W,
  input  logic       regwrite_E,
  input  logic       regwrite_M,
  input  logic       regwrite_W,
  input  logic       memtoreg_E,
  input  logic       memtoreg_M,
  input  logic       branch_D,
  input  logic       md_start_E,
  input  logic       md_op_E,
  output logic [1:0] forward_A_E,
  output logic [1:0] forward_B_E,
  output logic       forward_A_D,
  output logic       forward_B_D,
  output logic       stall_F,
  output logic       stall_D,
  output logic       stall_E,
  output logic       flush_E,
  output logic       md_go,
  output logic       md_op_q,
  output logic       md_busy,
  output logic       md_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t     state, state_next;
  logic [5:0] cnt, cnt_next;
  logic       op_q, op_q_next;
  logic       go_raw;

  logic [1:0] fwd_a_e, fwd_b_e;
  logic       fwd_a_d, fwd_b_d;
  logic       lwstall, brstall, mdstall;

  // Register 0 is hardwired, so it can never be a real producer.
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst,
                               input logic en);
    return en && (dst != 5'd0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (hit(src, writereg_M, regwrite_M))      return 2'b10;
    else if (hit(src, writereg_W, regwrite_W)) return 2'b01;
    else                                       return 2'b00;
  endfunction

  always_comb begin
    fwd_a_e = fwd_sel(rs_E);
    fwd_b_e = fwd_sel(rt_E);
    fwd_a_d = hit(rs_D, writereg_M, regwrite_M);
    fwd_b_d = hit(rt_D, writereg_M, regwrite_M);
    lwstall = hit(rs_D, writereg_E, memtoreg_E) ||
              hit(rt_D, writereg_E, memtoreg_E);
    brstall = branch_D &&
              (hit(rs_D, writereg_E, regwrite_E) || hit(rt_D, writereg_E, regwrite_E) ||
               hit(rs_D, writereg_M, memtoreg_M) || hit(rt_D, writereg_M, memtoreg_M));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 6'd0;
      op_q  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      op_q  <= op_q_next;
    end
  end

  // Starts are only accepted in IDLE; DONE always returns to IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    op_q_next  = op_q;
    go_raw     = 1'b0;
    case (state)
      IDLE: begin
        if (md_start_E) begin
          go_raw     = 1'b1;
          op_q_next  = md_op_E;
          cnt_next   = md_op_E ? DIV_LOAD : MUL_LOAD;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == 6'd0) state_next = DONE;
        else             cnt_next   = cnt - 6'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mdstall = go_raw || (state == RUN);

  // Every output is forced low while reset is held.
  always_comb begin
    forward_A_E = reset ? fwd_a_e : 2'b00;
    forward_B_E = reset ? fwd_b_e : 2'b00;
    forward_A_D = reset && fwd_a_d;
    forward_B_D = reset && fwd_b_d;
    stall_F     = reset && (lwstall || brstall || mdstall);
    stall_D     = reset && (lwstall || brstall || mdstall);
    stall_E     = reset && mdstall;
    flush_E     = reset && (lwstall || brstall) && !mdstall;
    md_go       = reset && go_raw;
    md_op_q     = reset && op_q;
    md_busy     = reset && (state == RUN);
    md_done     = reset && (state == DONE);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: timeline-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hazard_unit;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_e, rw_m, rw_w, mr_e, mr_m, br_d, start, op;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs_D = '0, rt_D = '0, rs_E = '0, rt_E = '0;
  logic [4:0] writereg_E = '0, writereg_M = '0, writereg_W = '0;
  logic       regwrite_E = 0, regwrite_M = 0, regwrite_W = 0;
  logic       memtoreg_E = 0, memtoreg_M = 0, branch_D = 0;
  logic       md_start_E = 0, md_op_E = 0;
  logic [1:0] forward_A_E, forward_B_E;
  logic       forward_A_D, forward_B_D, stall_F, stall_D, stall_E, flush_E;
  logic       md_go, md_op_q, md_busy, md_done;

  hazard_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
    .writereg_E(writereg_E), .writereg_M(writereg_M), .writereg_W(writereg_W),
    .regwrite_E(regwrite_E), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
    .memtoreg_E(memtoreg_E), .memtoreg_M(memtoreg_M), .branch_D(branch_D),
    .md_start_E(md_start_E), .md_op_E(md_op_E),
    .forward_A_E(forward_A_E), .forward_B_E(forward_B_E),
    .forward_A_D(forward_A_D), .forward_B_D(forward_B_D),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .flush_E(flush_E),
    .md_go(md_go), .md_op_q(md_op_q), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: cycle index of the last accepted launch and its length.
  int   cyc = 0;
  int   op_start = -1000;
  int   op_len = 0;
  logic op_q_m = 1'b0;

  task automatic cmp(input string name, input logic [1:0] got, input logic [1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst, input logic en);
    return en && dst != 0 && src == dst;
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    reset = s.rst;
    rs_D = s.rs_d; rt_D = s.rt_d; rs_E = s.rs_e; rt_E = s.rt_e;
    writereg_E = s.wr_e; writereg_M = s.wr_m; writereg_W = s.wr_w;
    regwrite_E = s.rw_e; regwrite_M = s.rw_m; regwrite_W = s.rw_w;
    memtoreg_E = s.mr_e; memtoreg_M = s.mr_m; branch_D = s.br_d;
    md_start_E = s.start; md_op_E = s.op;
    #1;
  endtask

  task automatic checkOutput();
    logic [1:0] e_fae, e_fbe;
    logic e_fad, e_fbd, lw, br, active, go, busy, done, ms, opq;
    e_fae = hit(rs_E, writereg_M, regwrite_M) ? 2'd2 : hit(rs_E, writereg_W, regwrite_W) ? 2'd1 : 2'd0;
    e_fbe = hit(rt_E, writereg_M, regwrite_M) ? 2'd2 : hit(rt_E, writereg_W, regwrite_W) ? 2'd1 : 2'd0;
    e_fad = hit(rs_D, writereg_M, regwrite_M);
    e_fbd = hit(rt_D, writereg_M, regwrite_M);
    lw = hit(rs_D, writereg_E, memtoreg_E) || hit(rt_D, writereg_E, memtoreg_E);
    br = branch_D && (hit(rs_D, writereg_E, regwrite_E) || hit(rt_D, writereg_E, regwrite_E) ||
                      hit(rs_D, writereg_M, memtoreg_M) || hit(rt_D, writereg_M, memtoreg_M));
    active = (cyc > op_start) && (cyc <= op_start + op_len + 1);
    go   = md_start_E && !active;
    busy = (cyc > op_start) && (cyc <= op_start + op_len);
    done = (cyc == op_start + op_len + 1);
    ms   = go || busy;
    opq  = op_q_m;
    if (!reset) begin
      e_fae = 0; e_fbe = 0; e_fad = 0; e_fbd = 0;
      lw = 0; br = 0; go = 0; busy = 0; done = 0; ms = 0; opq = 0;
    end
    cmp("forward_A_E", forward_A_E, e_fae);
    cmp("forward_B_E", forward_B_E, e_fbe);
    cmp("forward_A_D", forward_A_D, e_fad);
    cmp("forward_B_D", forward_B_D, e_fbd);
    cmp("stall_F", stall_F, lw || br || ms);
    cmp("stall_D", stall_D, lw || br || ms);
    cmp("stall_E", stall_E, ms);
    cmp("flush_E", flush_E, (lw || br) && !ms);
    cmp("md_go", md_go, go);
    cmp("md_op_q", md_op_q, opq);
    cmp("md_busy", md_busy, busy);
    cmp("md_done", md_done, done);
    if (!reset) begin
      op_start = -1000;
      op_q_m   = 1'b0;
    end else if (go) begin
      op_start = cyc;
      op_len   = md_op_E ? DIV_N : MUL_N;
      op_q_m   = md_op_E;
    end
    cyc++;
  endtask

  task automatic step(input stim_t s);
    applyStimulus(s);
    checkOutput();
  endtask

  task automatic doReset();
    stim_t s;
    s = '0;
    step(s);
    step(s);
  endtask

  initial begin
    stim_t s;
    doReset();
    cmp("reset_go", md_go, 1'b0);
    cmp("reset_stall", stall_F, 1'b0);

    // Forwarding priority: MEM over WB, register 0 never forwards
    s = quiet();
    s.rs_e = 5; s.wr_m = 5; s.rw_m = 1; s.wr_w = 5; s.rw_w = 1;
    step(s);
    cmp("lit_fwd_mem", forward_A_E, 2'b10);
    s.rw_m = 0;
    step(s);
    cmp("lit_fwd_wb", forward_A_E, 2'b01);
    s.rs_e = 0; s.wr_w = 0;
    step(s);
    cmp("lit_fwd_r0", forward_A_E, 2'b00);

    // Load-use hazard on rt_D
    s = quiet();
    s.mr_e = 1; s.wr_e = 7; s.rt_d = 7;
    step(s);
    cmp("lit_lw_stallF", stall_F, 1'b1);
    cmp("lit_lw_stallD", stall_D, 1'b1);
    cmp("lit_lw_flush", flush_E, 1'b1);
    cmp("lit_lw_stallE", stall_E, 1'b0);
    step(quiet());
    cmp("lit_lw_clear", stall_F, 1'b0);

    // Multiply: go in 0, stalls 0..4, done in 5
    doReset();
    for (int k = 0; k <= 6; k++) begin
      s = quiet(); s.start = (k <= 5); s.op = 0;
      step(s);
      cmp("lit_mul_go", md_go, k == 0);
      cmp("lit_mul_stall", stall_F, k <= 4);
      cmp("lit_mul_done", md_done, k == 5);
    end

    // Divide with a load-use hazard in cycle 3: never flushed, done in 33
    doReset();
    for (int k = 0; k <= 34; k++) begin
      s = quiet(); s.start = (k <= 33); s.op = 1;
      if (k == 3) begin s.mr_e = 1; s.wr_e = 7; s.rt_d = 7; end
      step(s);
      cmp("lit_div_flush", flush_E, 1'b0);
      cmp("lit_div_done", md_done, k == 33);
      cmp("lit_div_stall", stall_F, k <= 32);
    end

    // Reset in cycle 2 of a divide aborts it without md_done
    doReset();
    for (int k = 0; k <= 40; k++) begin
      s = quiet(); s.start = (k <= 2); s.op = 1; s.rst = (k != 2);
      if (k == 2) begin s.rs_e = 5; s.wr_m = 5; s.rw_m = 1; s.mr_e = 1; s.wr_e = 3; s.rs_d = 3; end
      step(s);
      if (k == 2) begin
        cmp("lit_rst_outs", {forward_A_E, stall_F, stall_E, flush_E, md_busy, md_go} == 0, 1'b1);
      end
      if (k >= 3) cmp("lit_rst_nodone", md_done, 1'b0);
      if (k == 3) cmp("lit_rst_idle", md_busy, 1'b0);
    end
    s = quiet(); s.start = 1;
    step(s);
    cmp("lit_rst_restart", md_go, 1'b1);
    for (int k = 0; k < 6; k++) step(quiet());

    // Back-to-back multiply then divide
    doReset();
    for (int k = 0; k <= 40; k++) begin
      s = quiet(); s.start = (k <= 39); s.op = (k >= 6);
      step(s);
      cmp("lit_b2b_go", md_go, (k == 0) || (k == 6));
      if (k >= 1) cmp("lit_b2b_opq", md_op_q, k >= 7);
    end

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      s.rst   = ($urandom_range(0, 63) != 0);
      s.rs_d  = 5'($urandom_range(0, 3)); s.rt_d = 5'($urandom_range(0, 3));
      s.rs_e  = 5'($urandom_range(0, 3)); s.rt_e = 5'($urandom_range(0, 3));
      s.wr_e  = 5'($urandom_range(0, 3)); s.wr_m = 5'($urandom_range(0, 3));
      s.wr_w  = 5'($urandom_range(0, 3));
      s.rw_e  = 1'($urandom); s.rw_m = 1'($urandom); s.rw_w = 1'($urandom);
      s.mr_e  = 1'($urandom); s.mr_m = 1'($urandom); s.br_d = 1'($urandom);
      s.start = ($urandom_range(0, 5) == 0);
      s.op    = 1'($urandom);
      step(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MUL_CYCLES, default 4: iterative multiply duration in cycles; legal range 2..63.
REQ-002 Parameter DIV_CYCLES, default 32: iterative divide duration in cycles; legal range 2..63.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 rs_D, rt_D  in  5 each  source register numbers in decode.
REQ-006 rs_E, rt_E  in  5 each  source register numbers in execute.
REQ-007 writereg_E, writereg_M, writereg_W  in  5 each  destination register per stage.
REQ-008 regwrite_E, regwrite_M, regwrite_W  in  1 each  destination write enable per stage.
REQ-009 memtoreg_E, memtoreg_M  in  1 each  stage holds a load.
REQ-010 branch_D  in  1  branch compare in decode.
REQ-011 md_start_E  in  1  multiply/divide instruction present in execute.
REQ-012 md_op_E  in  1  0 = multiply, 1 = divide.
REQ-013 forward_A_E, forward_B_E  out  2 each  execute mux3 selects: 00 register, 01 result_WB, 10 aluresult_MEM; 11 never driven.
REQ-014 forward_A_D, forward_B_D  out  1 each  decode branch comparator takes aluresult_MEM.
REQ-015 stall_F, stall_D, stall_E  out  1 each  hold the PC and the D and E pipeline registers.
REQ-016 flush_E  out  1  insert a bubble into the E register.
REQ-017 md_go  out  1  one-cycle launch pulse to the iterative mul/div datapath.
REQ-018 md_op_q  out  1  latched operation for the running mul/div.
REQ-019 md_busy, md_done  out  1 each  mul/div running; result valid this cycle.

Function
REQ-020 Register 0 never matches any hazard or forwarding comparison.
REQ-021 forward_A_E = 10 if rs_E==writereg_M and regwrite_M; else 01 if rs_E==writereg_W and regwrite_W; else 00. MEM priority over WB.
REQ-022 forward_B_E uses the same rule as REQ-021 with rt_E.
REQ-023 forward_A_D = (rs_D==writereg_M and regwrite_M); forward_B_D uses the same rule with rt_D.
REQ-024 lwstall = memtoreg_E and writereg_E in {rs_D, rt_D}.
REQ-025 brstall = branch_D and ((regwrite_E and writereg_E in {rs_D, rt_D}) or (memtoreg_M and writereg_M in {rs_D, rt_D})).
REQ-026 FSM states are IDLE, RUN and DONE, with a 6-bit down-counter cnt.
REQ-027 IDLE with md_start_E: md_go = 1; md_op_q <= md_op_E; cnt <= (md_op_E ? DIV_CYCLES : MUL_CYCLES) - 1; next state RUN.
REQ-028 RUN: cnt decrements each cycle; when cnt == 0 the next state is DONE, so RUN lasts exactly N cycles.
REQ-029 DONE: md_done = 1 for one cycle; next state IDLE unconditionally, with no start accepted in DONE.
REQ-030 mdstall = (IDLE and md_start_E) or RUN; md_busy = RUN.
REQ-031 stall_F = stall_D = lwstall or brstall or mdstall; stall_E = mdstall.
REQ-032 flush_E = (lwstall or brstall) and not mdstall, so a held mul/div instruction is never bubbled.
REQ-033 Latency: the mul/div instruction occupies EX for N+2 cycles and the pipeline is stalled for N+1 of them; md_done coincides with stall release.
REQ-034 md_start_E in the cycle after DONE starts a new operation in IDLE, so back-to-back mul/div is legal.
REQ-035 md_op_E changes during RUN are ignored; md_op_q holds until the next md_go.
REQ-036 Forwarding outputs are combinational and remain valid during stalls.

Reset
REQ-037 On a rising edge with reset = 0: state IDLE, cnt 0, md_op_q 0.
REQ-038 While reset = 0, all outputs are driven 0.
REQ-039 Reset asserted mid-RUN aborts the operation with no md_done pulse.

Verification
REQ-040 rs_E=5, writereg_M=5, regwrite_M=1, writereg_W=5, regwrite_W=1 -> forward_A_E=10; clear regwrite_M -> 01; rs_E=0 -> 00.
REQ-041 memtoreg_E=1, writereg_E=7, rt_D=7 -> stall_F=stall_D=flush_E=1, stall_E=0 for one cycle.
REQ-042 md_start_E=1, md_op_E=0, MUL_CYCLES=4 -> md_go in cycle 0; stalls high in cycles 0-4; md_done and stalls low in cycle 5.
REQ-043 Divide with DIV_CYCLES=32, coincident lwstall in cycle 3 -> flush_E stays 0 throughout; md_done in cycle 33.
REQ-044 Reset low in cycle 2 of a divide -> all outputs 0; after release, state IDLE with no md_done pulse.
REQ-045 Mul followed immediately by div -> md_go in cycles 0 and 6; md_op_q=1 from cycle 7.
